// File: rtl/s1s2_iter_ctrl_pkg.sv
// Shared helpers for the S1S2 iteration controller: index width and output bundle.
package s1s2_iter_ctrl_pkg;

    // Width of a pass index for n passes, never narrower than one bit.
    function automatic int clog2w(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    typedef struct packed {
        logic busy;
        logic finish;
        logic error;
        logic gen_start;
        logic cons_start;
        logic mem_owner;
    } ctrl_out_t;

endpackage

// File: rtl/s1s2_iter_ctrl_wdog.sv
// Watchdog counter: cleared before each wait phase, counts while enabled, saturates at all-ones.
module wdog_cnt #(
    parameter int TMO_W = 16
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TMO_W-1:0] cnt;

    assign expired = &cnt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

endmodule

// File: rtl/s1s2_iter_ctrl.sv
// Sequences iter generator/consumer passes over the shared S1S2 memory, with a
// per-phase watchdog. All outputs come straight from flops.
module s1s2_iter_ctrl
    import s1s2_iter_ctrl_pkg::*;
#(
    parameter int iter  = 5,
    parameter int TMO_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      start,
    input  logic                      abort,
    output logic                      busy,
    output logic                      finish,
    output logic                      error,
    output logic                      gen_start,
    output logic [clog2w(iter)-1:0]   gen_iterate,
    input  logic                      gen_finish,
    output logic                      cons_start,
    output logic [clog2w(iter)-1:0]   cons_stage,
    input  logic                      cons_done,
    output logic                      mem_owner
);

    localparam int KW = clog2w(iter);
    localparam logic [KW-1:0] K_LAST = KW'(iter - 1);

    typedef enum logic [2:0] {
        IDLE, GEN_KICK, GEN_WAIT, CONS_KICK, CONS_WAIT, DONE, ERR
    } state_t;

    state_t          state, state_nxt;
    logic [KW-1:0]   k, k_nxt;
    ctrl_out_t       out_q, out_nxt;
    logic            wd_clear, wd_en, wd_expired;

    // Both wait states are always entered from a kick state, so clearing there
    // presents a zero count on the first wait cycle.
    assign wd_clear = (state == GEN_KICK) || (state == CONS_KICK);
    assign wd_en    = (state == GEN_WAIT) || (state == CONS_WAIT);

    wdog_cnt #(.TMO_W(TMO_W)) u_wdog (
        .clk     (clk),
        .rst_b   (rst_b),
        .clear   (wd_clear),
        .enable  (wd_en),
        .expired (wd_expired)
    );

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = GEN_KICK;
                    k_nxt     = '0;
                end
            end
            GEN_KICK:  state_nxt = abort ? IDLE : GEN_WAIT;
            GEN_WAIT: begin
                if (abort)           state_nxt = IDLE;
                else if (gen_finish) state_nxt = CONS_KICK;
                else if (wd_expired) state_nxt = ERR;
            end
            CONS_KICK: state_nxt = abort ? IDLE : CONS_WAIT;
            CONS_WAIT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cons_done) begin
                    if (k == K_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = GEN_KICK;
                        k_nxt     = k + KW'(1);
                    end
                end else if (wd_expired) begin
                    state_nxt = ERR;
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = abort ? IDLE : ERR;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up
    // with the state they describe without any input-to-output path.
    always_comb begin
        out_nxt = '0;
        case (state_nxt)
            GEN_KICK: begin
                out_nxt.busy      = 1'b1;
                out_nxt.gen_start = 1'b1;
            end
            GEN_WAIT:  out_nxt.busy = 1'b1;
            CONS_KICK: begin
                out_nxt.busy       = 1'b1;
                out_nxt.cons_start = 1'b1;
                out_nxt.mem_owner  = 1'b1;
            end
            CONS_WAIT: begin
                out_nxt.busy      = 1'b1;
                out_nxt.mem_owner = 1'b1;
            end
            DONE: begin
                out_nxt.busy   = 1'b1;
                out_nxt.finish = 1'b1;
            end
            ERR: begin
                out_nxt.busy  = 1'b1;
                out_nxt.error = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
            k     <= '0;
            out_q <= '0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            out_q <= out_nxt;
        end
    end

    assign busy        = out_q.busy;
    assign finish      = out_q.finish;
    assign error       = out_q.error;
    assign gen_start   = out_q.gen_start;
    assign cons_start  = out_q.cons_start;
    assign mem_owner   = out_q.mem_owner;
    assign gen_iterate = k;
    assign cons_stage  = k;

endmodule

// File: tb/tb_s1s2_iter_ctrl.sv
// Bench for s1s2_iter_ctrl: three configurations (iter=5, iter=1, iter=3/TMO_W=4)
// driven by a responder and checked against a cycle schedule built from pass latencies.
module tb_s1s2_iter_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_b;
    logic start, abort, gen_finish, cons_done;
    int   sel;

    logic st_w[3], ab_w[3], gf_w[3], cd_w[3];
    logic busy_w[3], fin_w[3], err_w[3], gs_w[3], cs_w[3], mo_w[3];
    logic [2:0] gi0, cst0;
    logic [0:0] gi1, cst1;
    logic [1:0] gi2, cst2;

    for (genvar i = 0; i < 3; i++) begin : g_in
        assign st_w[i] = start      && (sel == i);
        assign ab_w[i] = abort      && (sel == i);
        assign gf_w[i] = gen_finish && (sel == i);
        assign cd_w[i] = cons_done  && (sel == i);
    end

    s1s2_iter_ctrl #(.iter(5), .TMO_W(16)) dut5 (
        .clk(clk), .rst_b(rst_b), .start(st_w[0]), .abort(ab_w[0]),
        .busy(busy_w[0]), .finish(fin_w[0]), .error(err_w[0]),
        .gen_start(gs_w[0]), .gen_iterate(gi0), .gen_finish(gf_w[0]),
        .cons_start(cs_w[0]), .cons_stage(cst0), .cons_done(cd_w[0]),
        .mem_owner(mo_w[0])
    );

    s1s2_iter_ctrl #(.iter(1), .TMO_W(16)) dut1 (
        .clk(clk), .rst_b(rst_b), .start(st_w[1]), .abort(ab_w[1]),
        .busy(busy_w[1]), .finish(fin_w[1]), .error(err_w[1]),
        .gen_start(gs_w[1]), .gen_iterate(gi1), .gen_finish(gf_w[1]),
        .cons_start(cs_w[1]), .cons_stage(cst1), .cons_done(cd_w[1]),
        .mem_owner(mo_w[1])
    );

    s1s2_iter_ctrl #(.iter(3), .TMO_W(4)) dut3 (
        .clk(clk), .rst_b(rst_b), .start(st_w[2]), .abort(ab_w[2]),
        .busy(busy_w[2]), .finish(fin_w[2]), .error(err_w[2]),
        .gen_start(gs_w[2]), .gen_iterate(gi2), .gen_finish(gf_w[2]),
        .cons_start(cs_w[2]), .cons_stage(cst2), .cons_done(cd_w[2]),
        .mem_owner(mo_w[2])
    );

    logic o_busy, o_fin, o_err, o_gs, o_cs, o_mo;
    int   o_gi, o_cst;

    always_comb begin
        o_busy = busy_w[sel];
        o_fin  = fin_w[sel];
        o_err  = err_w[sel];
        o_gs   = gs_w[sel];
        o_cs   = cs_w[sel];
        o_mo   = mo_w[sel];
        case (sel)
            0:       begin o_gi = {29'b0, gi0}; o_cst = {29'b0, cst0}; end
            1:       begin o_gi = {31'b0, gi1}; o_cst = {31'b0, cst1}; end
            default: begin o_gi = {30'b0, gi2}; o_cst = {30'b0, cst2}; end
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;
    int g_lat[16];
    int c_lat[16];

    function automatic int iter_of(input int s);
        case (s)
            0:       return 5;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    // One job: start, answer each gen_start/cons_start after the chosen latency,
    // and compare every pulse against the schedule implied by those latencies.
    task automatic run_job(input int abort_pass, input bit noise, input string tag);
        int n, c0, t, end_cyc, abort_cyc, n_exp, bad_prof, gen_due, cons_due, m;
        int exp_gs[$], exp_cs[$], gs_cyc[$], gs_it[$], cs_cyc[$], cs_stg[$], fin_cyc[$];
        bit exp_busy, exp_mo, win_g, win_c;
        n = iter_of(sel);
        @(negedge clk);
        c0 = cyc;
        start = 1'b1;
        t = c0 + 1;
        for (int p = 0; p < n; p++) begin
            exp_gs.push_back(t);
            exp_cs.push_back(t + g_lat[p] + 1);
            t = t + g_lat[p] + c_lat[p] + 2;
        end
        abort_cyc = -1;
        if (abort_pass >= 0) begin
            abort_cyc = exp_cs[abort_pass] + c_lat[abort_pass];
            end_cyc   = abort_cyc;
            n_exp     = abort_pass + 1;
        end else begin
            end_cyc = t;
            n_exp   = n;
        end
        gen_due = -1; cons_due = -1; bad_prof = 0;
        while (cyc < end_cyc + 3) begin
            @(negedge clk);
            if (o_gs) begin
                gs_cyc.push_back(cyc);
                gs_it.push_back(o_gi);
                if (gs_cyc.size() <= 16) gen_due = cyc + g_lat[gs_cyc.size() - 1];
            end
            if (o_cs) begin
                cs_cyc.push_back(cyc);
                cs_stg.push_back(o_cst);
                if (cs_cyc.size() <= 16) cons_due = cyc + c_lat[cs_cyc.size() - 1];
            end
            if (o_fin) fin_cyc.push_back(cyc);
            exp_busy = (cyc > c0) && (cyc <= end_cyc);
            exp_mo = 1'b0; win_g = 1'b0; win_c = 1'b0;
            for (int p = 0; p < n_exp; p++) begin
                if (cyc >= exp_cs[p] && cyc <= exp_cs[p] + c_lat[p]) exp_mo = 1'b1;
                if (cyc >= exp_gs[p] && cyc < exp_gs[p] + g_lat[p]) win_g = 1'b1;
                if (cyc >= exp_cs[p] && cyc < exp_cs[p] + c_lat[p]) win_c = 1'b1;
            end
            if (o_busy !== exp_busy || o_mo !== exp_mo || o_err !== 1'b0) bad_prof++;
            start      = noise && (cyc <= end_cyc) && ($urandom_range(0, 2) == 0);
            gen_finish = (cyc == gen_due) || (noise && win_c && ($urandom_range(0, 2) == 0));
            cons_done  = (cyc == cons_due) || (noise && win_g && ($urandom_range(0, 2) == 0));
            abort      = (cyc == abort_cyc);
        end
        start = 1'b0; gen_finish = 1'b0; cons_done = 1'b0; abort = 1'b0;

        n_checks++;
        if (gs_cyc.size() !== n_exp) begin
            n_fail++;
            $display("FAIL %s gen_start count: got %0d want %0d", tag, gs_cyc.size(), n_exp);
        end
        m = (gs_cyc.size() < n_exp) ? gs_cyc.size() : n_exp;
        for (int p = 0; p < m; p++) begin
            n_checks++;
            if (gs_cyc[p] !== exp_gs[p]) begin
                n_fail++;
                $display("FAIL %s gen_start[%0d] cycle: got %0d want %0d", tag, p, gs_cyc[p], exp_gs[p]);
            end
            n_checks++;
            if (gs_it[p] !== p) begin
                n_fail++;
                $display("FAIL %s gen_iterate[%0d]: got %0d want %0d", tag, p, gs_it[p], p);
            end
        end
        n_checks++;
        if (cs_cyc.size() !== n_exp) begin
            n_fail++;
            $display("FAIL %s cons_start count: got %0d want %0d", tag, cs_cyc.size(), n_exp);
        end
        m = (cs_cyc.size() < n_exp) ? cs_cyc.size() : n_exp;
        for (int p = 0; p < m; p++) begin
            n_checks++;
            if (cs_cyc[p] !== exp_cs[p]) begin
                n_fail++;
                $display("FAIL %s cons_start[%0d] cycle: got %0d want %0d", tag, p, cs_cyc[p], exp_cs[p]);
            end
            n_checks++;
            if (cs_stg[p] !== p) begin
                n_fail++;
                $display("FAIL %s cons_stage[%0d]: got %0d want %0d", tag, p, cs_stg[p], p);
            end
        end
        n_checks++;
        if (fin_cyc.size() !== ((abort_pass >= 0) ? 0 : 1)) begin
            n_fail++;
            $display("FAIL %s finish count: got %0d want %0d", tag, fin_cyc.size(), (abort_pass >= 0) ? 0 : 1);
        end else if (abort_pass < 0) begin
            n_checks++;
            if (fin_cyc[0] !== end_cyc) begin
                n_fail++;
                $display("FAIL %s finish cycle: got %0d want %0d", tag, fin_cyc[0], end_cyc);
            end
        end
        n_checks++;
        if (bad_prof !== 0) begin
            n_fail++;
            $display("FAIL %s busy/mem_owner/error profile: got %0d bad cycles want 0", tag, bad_prof);
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            n_checks++;
            if ({o_busy, o_fin, o_err, o_gs, o_cs, o_mo} !== 6'b0 || o_gi !== 0 || o_cst !== 0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: got %b/%0d/%0d want 000000/0/0", s,
                         {o_busy, o_fin, o_err, o_gs, o_cs, o_mo}, o_gi, o_cst);
            end
        end
        sel = 0;
        @(negedge clk);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset busy: got %b want 0", o_busy);
        end
    endtask

    task automatic test_nominal();
        sel = 0;
        for (int p = 0; p < 16; p++) begin g_lat[p] = 10; c_lat[p] = 10; end
        run_job(-1, 1'b0, "nominal");
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            sel = (r % 2 == 0) ? 0 : 2;
            for (int p = 0; p < 16; p++) begin
                g_lat[p] = $urandom_range(1, 12);
                c_lat[p] = $urandom_range(1, 12);
            end
            run_job(-1, 1'b1, "random");
        end
    endtask

    // Done pulse arrives exactly on the cycle the counter shows all-ones.
    task automatic test_watchdog_boundary();
        sel = 2;
        for (int p = 0; p < 16; p++) begin g_lat[p] = 16; c_lat[p] = 16; end
        run_job(-1, 1'b0, "wdog_done_wins");
    endtask

    task automatic test_watchdog();
        int c0, first_err, bad;
        bit exp_err;
        sel = 2;
        @(negedge clk);
        c0 = cyc;
        start = 1'b1;
        first_err = -1;
        bad = 0;
        // GEN_KICK at c0+1, 16 GEN_WAIT cycles (count 0..15), ERR from c0+18.
        while (cyc < c0 + 24) begin
            @(negedge clk);
            if (o_err && first_err < 0) first_err = cyc;
            exp_err = (cyc >= c0 + 18);
            if (o_err !== exp_err || o_busy !== 1'b1 || o_gs !== (cyc == c0 + 1) ||
                o_cs !== 1'b0 || o_mo !== 1'b0 || o_fin !== 1'b0) bad++;
            start      = exp_err && ($urandom_range(0, 1) == 0);
            gen_finish = exp_err && ($urandom_range(0, 1) == 0);
            cons_done  = exp_err && ($urandom_range(0, 1) == 0);
        end
        start = 1'b0; gen_finish = 1'b0; cons_done = 1'b0;
        n_checks++;
        if (first_err !== c0 + 18) begin
            n_fail++;
            $display("FAIL wdog error rise cycle: got %0d want %0d", first_err, c0 + 18);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL wdog output profile: got %0d bad cycles want 0", bad);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (o_busy !== 1'b0 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wdog abort exit: got busy=%b error=%b want 0 0", o_busy, o_err);
        end
    endtask

    task automatic test_abort_priority();
        sel = 0;
        for (int p = 0; p < 16; p++) begin
            g_lat[p] = $urandom_range(1, 8);
            c_lat[p] = $urandom_range(1, 8);
        end
        run_job(2, 1'b1, "abort_k2");
        run_job(-1, 1'b0, "restart_after_abort");
    endtask

    task automatic test_iter1();
        sel = 1;
        for (int p = 0; p < 16; p++) begin g_lat[p] = 1; c_lat[p] = 1; end
        run_job(-1, 1'b0, "iter1_fast");
        g_lat[0] = $urandom_range(2, 12);
        c_lat[0] = $urandom_range(2, 12);
        run_job(-1, 1'b1, "iter1_random");
    endtask

    task automatic test_reset_midrun();
        int c0, fins, busys;
        sel = 0;
        @(negedge clk);
        c0 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 5) @(negedge clk);
        gen_finish = 1'b1;
        @(negedge clk);
        gen_finish = 1'b0;
        n_checks++;
        if (o_cs !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun cons_start: got %b want 1", o_cs);
        end
        @(negedge clk);
        #2 rst_b = 1'b0;
        #1;
        n_checks++;
        if ({o_busy, o_fin, o_err, o_gs, o_cs, o_mo} !== 6'b0 || o_gi !== 0 || o_cst !== 0) begin
            n_fail++;
            $display("FAIL midrun async reset outputs: got %b/%0d/%0d want 000000/0/0",
                     {o_busy, o_fin, o_err, o_gs, o_cs, o_mo}, o_gi, o_cst);
        end
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        fins = 0; busys = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (o_fin) fins++;
            if (o_busy) busys++;
            cons_done  = ($urandom_range(0, 3) == 0);
            gen_finish = ($urandom_range(0, 3) == 0);
        end
        cons_done = 1'b0; gen_finish = 1'b0;
        n_checks++;
        if (fins !== 0 || busys !== 0) begin
            n_fail++;
            $display("FAIL midrun after release: got finish=%0d busy=%0d cycles want 0 0", fins, busys);
        end
    endtask

    initial begin
        sel = 0;
        start = 1'b0; abort = 1'b0; gen_finish = 1'b0; cons_done = 1'b0;
        test_reset();
        test_nominal();
        test_random();
        test_watchdog_boundary();
        test_watchdog();
        test_abort_priority();
        test_iter1();
        test_reset_midrun();
        test_nominal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global timeout: got no completion want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/s1s2_iter_ctrl.md
S1S2_ITER_CTRL -- requirements
Module: s1s2_iter_ctrl

Interface
REQ-001 SHALL have parameter iter, default 5, meaning the number of S1S2 generation passes (iterate = 0..iter-1); legal range 1..16.
REQ-002 SHALL have parameter TMO_W, default 16, meaning the watchdog counter width in bits.
REQ-003 SHALL have port clk, input, 1, meaning the single clock, rising edge.
REQ-004 SHALL have port rst_b, input, 1, meaning reset, asynchronous active-low.
REQ-005 SHALL have port start, input, 1, meaning the run request, sampled in IDLE only.
REQ-006 SHALL have port abort, input, 1, meaning the synchronous abort of the run.
REQ-007 SHALL have port busy, output, 1, meaning high in every state except IDLE.
REQ-008 SHALL have port finish, output, 1, meaning a one-cycle pulse when all passes complete.
REQ-009 SHALL have port error, output, 1, meaning watchdog expiry, held high until cleared.
REQ-010 SHALL have port gen_start, output, 1, meaning the one-cycle start pulse to the S1S2 generator.
REQ-011 SHALL have port gen_iterate, output, CLOG2(iter), meaning the pass index driven to the generator.
REQ-012 SHALL have port gen_finish, input, 1, meaning the generator-done pulse.
REQ-013 SHALL have port cons_start, output, 1, meaning the one-cycle start pulse to the downstream consumer.
REQ-014 SHALL have port cons_stage, output, CLOG2(iter), meaning the pass index driven to the consumer.
REQ-015 SHALL have port cons_done, input, 1, meaning the consumer-done pulse.
REQ-016 SHALL have port mem_owner, output, 1, meaning the S1S2 memory port select (0 = generator, 1 = consumer).

Function
REQ-017 SHALL implement states IDLE, GEN_KICK, GEN_WAIT, CONS_KICK, CONS_WAIT, DONE and ERR.
REQ-018 SHALL transition IDLE->GEN_KICK when start=1, and SHALL clear the pass counter k to 0 on that transition.
REQ-019 SHALL stay in GEN_KICK for exactly 1 cycle, with gen_start=1 in that cycle, then go to GEN_WAIT.
REQ-020 SHALL hold gen_iterate=k stable from GEN_KICK through GEN_WAIT, because the generator reads iterate combinationally for its whole run.
REQ-021 SHALL transition GEN_WAIT->CONS_KICK on gen_finish=1.
REQ-022 SHALL stay in CONS_KICK for exactly 1 cycle, with cons_start=1 in that cycle, then go to CONS_WAIT, and SHALL hold cons_stage=k in both states.
REQ-023 SHALL drive mem_owner=1 in CONS_KICK and CONS_WAIT and mem_owner=0 in all other states.
REQ-024 SHALL, on cons_done=1 in CONS_WAIT, go to DONE if k==iter-1, else increment k and go to GEN_KICK.
REQ-025 SHALL stay in DONE for exactly 1 cycle with finish=1, then go to IDLE.
REQ-026 SHALL ignore gen_finish outside GEN_WAIT, cons_done outside CONS_WAIT, and start outside IDLE.
REQ-027 SHALL clear the watchdog counter on entry to GEN_WAIT and to CONS_WAIT, and SHALL increment it by 1 per cycle in those states.
REQ-028 SHALL go to ERR with error=1 when the watchdog reaches 2^TMO_W-1 and no done pulse is present in that cycle; a done pulse in that cycle wins.
REQ-029 SHALL, in ERR, hold error=1 and force gen_start=cons_start=0, and SHALL exit to IDLE only on abort=1.
REQ-030 SHALL, on abort=1 in any busy state, go to IDLE on the next edge, with no finish pulse and error cleared; abort takes priority over gen_finish and cons_done in the same cycle.
REQ-031 SHALL drive gen_start, cons_start, finish, error, busy, mem_owner, gen_iterate and cons_stage from registers, with no combinational input-to-output path.
REQ-032 SHALL support iter=1: exactly one generator/consumer pair runs, then finish.

Reset
REQ-033 SHALL, on rst_b=0 (asynchronous), force state=IDLE, k=0, watchdog=0 and all outputs to 0.
REQ-034 SHALL, when reset is asserted mid-run, abandon the run with no finish pulse; after release, the block waits for a new start.

Structure
REQ-035 SHALL take the CLOG2 macro and shared widths from the common define.v/clog2.v include set; state encodings SHALL be local parameters of the module.
REQ-036 SHALL place the watchdog in one sub-module, wdog_cnt (clear, enable, expired), parameterised by TMO_W.

Verification
REQ-037 SHALL cover the nominal run: iter=5, start pulse, generator/consumer done after 10 cycles each -> 5 gen_start pulses with gen_iterate 0,1,2,3,4, 5 cons_start pulses, and finish 1 cycle after the 5th cons_done.
REQ-038 SHALL cover an early done: gen_finish pulsed in CONS_WAIT -> no state change; mem_owner stays 1 until cons_done.
REQ-039 SHALL cover watchdog expiry: TMO_W=4 and gen_finish withheld -> error=1 after 15 cycles in GEN_WAIT; abort -> IDLE, error=0.
REQ-040 SHALL cover abort priority: abort and cons_done in the same cycle at k=2 -> IDLE, no finish, and the next start begins with gen_iterate=0.
REQ-041 SHALL cover reset mid-run: rst_b low during CONS_WAIT -> all outputs 0 immediately, and no finish after release.
REQ-042 SHALL cover iter=1: a single pass -> exactly one gen_start and one cons_start, then finish.
